// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Fetch-stage bundle: instruction-ROM port, decode handshake,
//            redirect/halt controls and status flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus4_o;
    logic              valid_o;
    logic              ready_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_target_i;
    logic              halt_i;
    logic              halted_o;
    logic              misalign_o;

    modport master (
        output imem_addr, instr_o, pc_o, pc_plus4_o, valid_o, halted_o, misalign_o,
        input  imem_rdata, ready_i, redirect_i, redirect_target_i, halt_i
    );

    modport slave (
        input  imem_addr, instr_o, pc_o, pc_plus4_o, valid_o, halted_o, misalign_o,
        output imem_rdata, ready_i, redirect_i, redirect_target_i, halt_i
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : PC and fetch register with valid/ready hand-off to decode,
//            redirect, stall and halt. FETCH_MISALIGN_TRAP_EN selects trapping
//            (vs. masking) of misaligned redirect targets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);
    localparam logic [1:0] C_BOOT = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_HALT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fpc_d      = fpc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        case (state_q)
            C_BOOT: state_d = C_RUN;
            C_RUN: begin
                if (bus.halt_i) begin
                    state_d = C_HALT;
                end else if (bus.redirect_i) begin
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (bus.redirect_target_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = C_HALT;
                    end else begin
                        pc_d = bus.redirect_target_i;
                    end
`else
                    pc_d = bus.redirect_target_i & ~ADDR_W'(3);
`endif
                end else if (!valid_q || bus.ready_i) begin
                    instr_d = bus.imem_rdata;
                    fpc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + ADDR_W'(4);
                end
            end
            C_HALT: begin
                // Only a drain of the pending instruction is allowed here.
                if (valid_q && bus.ready_i) valid_d = 1'b0;
            end
            default: state_d = C_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= C_BOOT;
            pc_q       <= RESET_PC;
            fpc_q      <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fpc_q      <= fpc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.instr_o    = instr_q;
    assign bus.pc_o       = fpc_q;
    assign bus.pc_plus4_o = fpc_q + ADDR_W'(4);
    assign bus.valid_o    = valid_q;
    assign bus.halted_o   = (state_q == C_HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign_o = misalign_q;
`else
    assign bus.misalign_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-register stage directly upstream of the instruction memory in the single-cycle RISC-V core. Drives the 8-bit byte address into the combinational instruction ROM. Captures the returned 32-bit word into a registered instruction/PC pair, which it hands to decode over a valid/ready handshake. Also handles branch/jump redirects, stalls, wrap-around and halt.

## Interface
- ADDR_W, 8: width of the instruction address bus (byte address).
- RESET_PC, 8'h00: PC value loaded on reset.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals the current PC register.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- instr_o  out  32  registered instruction for decode.
- pc_o  out  ADDR_W  address that instr_o was fetched from.
- pc_plus4_o  out  ADDR_W  pc_o + 4, modulo 2^ADDR_W (link value for JAL/JALR).
- valid_o  out  1  instr_o/pc_o hold an instruction not yet accepted.
- ready_i  in  1  decode accepts instr_o this cycle when valid_o=1.
- redirect_i  in  1  taken branch/jump; flushes the fetch register.
- redirect_target_i  in  ADDR_W  new PC when redirect_i=1.
- halt_i  in  1  request to stop fetching.
- halted_o  out  1  state is HALT.
- misalign_o  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States: BOOT, RUN, HALT.
- Reset (rst=1 at edge):
  - state=BOOT; PC=RESET_PC; instr_o=32'h0; pc_o=RESET_PC; pc_plus4_o=RESET_PC+4.
  - valid_o=0; halted_o=0; misalign_o=0.
- BOOT: one idle cycle with no capture, then go to RUN.
- RUN priority, evaluated per edge:
  1. halt_i=1: go to HALT; PC frozen; redirect_i ignored in the same cycle; valid_o and instr_o keep their current values.
  2. redirect_i=1: PC=redirect_target_i; valid_o=0 (flush); instr_o/pc_o unchanged. This applies even when valid_o=1 and ready_i=0.
  3. Advance when valid_o=0 or ready_i=1: instr_o=imem_rdata; pc_o=PC; valid_o=1; PC=PC+4.
  4. Otherwise stall: all registers hold.
- HALT:
  - No further capture; PC frozen; redirect_i ignored.
  - If valid_o=1 and ready_i=1, valid_o becomes 0. Otherwise valid_o holds.
  - halted_o=1. Only rst exits HALT.
- Arithmetic: PC+4 truncates to ADDR_W. With ADDR_W=8, 0xFC advances to 0x00.
- An all-zero instruction word is passed through unchanged; fetch does not decode it.

## Timing
- Single-cycle ROM path: imem_addr to imem_rdata to the instr_o D input within one cycle.
- Reset release to first valid_o=1: 2 edges (BOOT edge, then first RUN capture at RESET_PC).
- Redirect at edge N: valid_o=0 after N; instruction from the target is valid after N+1.
- Back-to-back throughput with ready_i held at 1: one instruction per cycle.
- ready_i=0 with valid_o=1: instr_o, pc_o and PC are all stable until acceptance.
- halt_i at edge N: halted_o=1 after N.
- rst asserted mid-operation: all outputs return to reset values after that edge, regardless of state or pending handshake.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - Redirect in RUN with redirect_target_i[1:0]≠0 sets misalign_o=1 (sticky until rst).
  - State goes to HALT; PC unchanged; valid_o=0.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirect_target_i[1:0] is masked to 2'b00 before loading PC.
  - misalign_o is tied 0.

## Test plan
- Reset, then ready_i=1: valid_o rises on the 2nd edge with pc_o=0x00. Subsequent edges give pc_o=0x04, 0x08, 0x0C, each with instr_o = ROM word at that address and pc_plus4_o = pc_o+4.
- ready_i=0 for 3 cycles with pc_o=0x08 held: instr_o, pc_o and imem_addr=0x0C stay constant. Raising ready_i gives pc_o=0x0C on the next edge.
- redirect_i=1, target 0x1C, while valid_o=1 and ready_i=0: valid_o=0 next cycle. The following cycle gives pc_o=0x1C and instr_o = ROM word at 0x1C.
- Wrap-around: redirect to 0xFC gives pc_o=0xFC with pc_plus4_o=0x00, then pc_o=0x00.
- halt_i and redirect_i (target 0x10) asserted together: redirect ignored, halted_o=1, PC frozen. A pending instruction drains on ready_i. rst returns to BOOT with pc_o=0x00.
- Misaligned redirect to 0x06:
  - Macro defined: misalign_o=1, halted_o=1, valid_o=0.
  - Macro undefined: next valid pc_o=0x04, misalign_o=0.
